// File: rtl/ovl_impl_win_pkg.sv
// Shared types and helpers for the windowed implication checker.
// Fire vectors are indexed by the FIRE_* kinds below.
package ovl_impl_win_pkg;

   typedef enum logic {IDLE, WAIT} win_state_t;

   localparam int FIRE_KINDS   = 2;
   localparam int FIRE_TIMEOUT = 0;
   localparam int FIRE_EARLY   = 1;

   // Delay counter width; never narrower than one bit, even for a 0/0 window.
   function automatic int cnt_width(input int max_delay);
      int w;
      w = $clog2(max_delay + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/ovl_impl_win_chan.sv
// One implication channel: IDLE/WAIT window tracker with a delay counter.
// Emits registered timeout/early fire pulses one cycle after detection.
module ovl_impl_win_chan
   import ovl_impl_win_pkg::*;
#(
   parameter int MIN_DELAY    = 0,
   parameter int MAX_DELAY    = 4,
   parameter int STRICT_EARLY = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable_i,
   input  logic                  ante_i,
   input  logic                  cons_i,
   output logic                  pending_o,
   output logic [FIRE_KINDS-1:0] fire_o
);

   localparam int            CW    = cnt_width(MAX_DELAY);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_DELAY);

   win_state_t            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [FIRE_KINDS-1:0] fire_q, fire_d;
   logic                  in_early;

   // Cycles 1..MIN_DELAY-1 of a window; empty when MIN_DELAY is 0.
   if (MIN_DELAY == 0) begin : g_no_early
      assign in_early = 1'b0;
   end else begin : g_early
      localparam logic [CW-1:0] MIN_C = CW'(MIN_DELAY);
      assign in_early = (cnt_q < MIN_C);
   end

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      fire_d  = '0;
      if (!enable_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ante_i) begin
                  if (MIN_DELAY == 0 && cons_i) begin
                     state_d = IDLE;
                  end else if (MAX_DELAY == 0) begin
                     fire_d[FIRE_TIMEOUT] = 1'b1;
                  end else begin
                     state_d = WAIT;
                     cnt_d   = CW'(1);
                  end
               end
            end
            WAIT: begin
               // Antecedents seen here are dropped: windows never overlap.
               if (cons_i && !in_early) begin
                  state_d = IDLE;
               end else if (cons_i && STRICT_EARLY != 0) begin
                  fire_d[FIRE_EARLY] = 1'b1;
                  state_d            = IDLE;
               end else if (cnt_q == MAX_C) begin
                  fire_d[FIRE_TIMEOUT] = 1'b1;
                  state_d              = IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fire_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fire_q  <= fire_d;
      end
   end

   assign pending_o = (state_q == WAIT);
   assign fire_o    = fire_q;

endmodule

// File: rtl/ovl_implication_window.sv
// Multi-channel windowed implication checker: per-channel window FSMs plus
// a shared sticky error flag and saturating violation counter.
module ovl_implication_window
   import ovl_impl_win_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int MIN_DELAY    = 0,
   parameter int MAX_DELAY    = 4,
   parameter int STRICT_EARLY = 0,
   parameter int CNT_W        = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear_sticky,
   input  logic [NUM_CH-1:0] antecedent_expr,
   input  logic [NUM_CH-1:0] consequent_expr,
   output logic [NUM_CH-1:0] pending,
   output logic [NUM_CH-1:0] fire_timeout,
   output logic [NUM_CH-1:0] fire_early,
   output logic              error_sticky,
   output logic [CNT_W-1:0]  fire_count
);

   localparam int PW = $clog2(NUM_CH + 1);

   if (MIN_DELAY > MAX_DELAY || NUM_CH < 1) begin : g_bad_params
      $fatal(1, "ovl_implication_window: need NUM_CH>=1 and MIN_DELAY<=MAX_DELAY");
   end

   logic [FIRE_KINDS-1:0] chan_fire [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      ovl_impl_win_chan #(
         .MIN_DELAY   (MIN_DELAY),
         .MAX_DELAY   (MAX_DELAY),
         .STRICT_EARLY(STRICT_EARLY)
      ) u_chan (
         .clock    (clock),
         .reset    (reset),
         .enable_i (enable),
         .ante_i   (antecedent_expr[i]),
         .cons_i   (consequent_expr[i]),
         .pending_o(pending[i]),
         .fire_o   (chan_fire[i])
      );
      assign fire_timeout[i] = chan_fire[i][FIRE_TIMEOUT];
      assign fire_early[i]   = chan_fire[i][FIRE_EARLY];
   end

   logic [NUM_CH-1:0]   fire_any;
   logic [PW-1:0]       pop;
   logic [CNT_W-1:0]    count_base;
   logic [CNT_W+PW-1:0] count_sum;
   logic [CNT_W-1:0]    fire_count_q, fire_count_d;
   logic                sticky_q, sticky_d;

   // A clear drops the old totals; fires of the same cycle land on top of zero.
   always_comb begin
      fire_any = fire_timeout | fire_early;
      pop      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         pop = pop + PW'(fire_any[i]);
      end
      count_base   = clear_sticky ? '0 : fire_count_q;
      count_sum    = {{PW{1'b0}}, count_base} + {{CNT_W{1'b0}}, pop};
      fire_count_d = (|count_sum[CNT_W+PW-1:CNT_W]) ? '1 : count_sum[CNT_W-1:0];
      sticky_d     = (sticky_q & ~clear_sticky) | (|fire_any);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fire_count_q <= '0;
         sticky_q     <= 1'b0;
      end else begin
         fire_count_q <= fire_count_d;
         sticky_q     <= sticky_d;
      end
   end

   assign fire_count   = fire_count_q;
   assign error_sticky = sticky_q;

endmodule

// File: tb/tb_ovl_implication_window.sv
// Directed bench for ovl_implication_window: three configurations share one
// stimulus stream (base MIN=1/MAX=3, strict-early MIN=2, and a 2-bit counter).
module tb_ovl_implication_window;

   logic       clock = 1'b0;
   logic       reset, enable, clear_sticky;
   logic [3:0] ante, cons;

   logic [3:0] pending_a, fire_timeout_a, fire_early_a;
   logic [3:0] pending_e, fire_timeout_e, fire_early_e;
   logic [3:0] pending_s, fire_timeout_s, fire_early_s;
   logic       error_sticky_a, error_sticky_e, error_sticky_s;
   logic [7:0] fire_count_a, fire_count_e;
   logic [1:0] fire_count_s;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clock = ~clock;

   ovl_implication_window #(.NUM_CH(4), .MIN_DELAY(1), .MAX_DELAY(3), .STRICT_EARLY(0), .CNT_W(8)) dut_a (
      .clock(clock), .reset(reset), .enable(enable), .clear_sticky(clear_sticky),
      .antecedent_expr(ante), .consequent_expr(cons),
      .pending(pending_a), .fire_timeout(fire_timeout_a), .fire_early(fire_early_a),
      .error_sticky(error_sticky_a), .fire_count(fire_count_a));

   ovl_implication_window #(.NUM_CH(4), .MIN_DELAY(2), .MAX_DELAY(3), .STRICT_EARLY(1), .CNT_W(8)) dut_e (
      .clock(clock), .reset(reset), .enable(enable), .clear_sticky(clear_sticky),
      .antecedent_expr(ante), .consequent_expr(cons),
      .pending(pending_e), .fire_timeout(fire_timeout_e), .fire_early(fire_early_e),
      .error_sticky(error_sticky_e), .fire_count(fire_count_e));

   ovl_implication_window #(.NUM_CH(4), .MIN_DELAY(1), .MAX_DELAY(3), .STRICT_EARLY(0), .CNT_W(2)) dut_s (
      .clock(clock), .reset(reset), .enable(enable), .clear_sticky(clear_sticky),
      .antecedent_expr(ante), .consequent_expr(cons),
      .pending(pending_s), .fire_timeout(fire_timeout_s), .fire_early(fire_early_s),
      .error_sticky(error_sticky_s), .fire_count(fire_count_s));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Apply one cycle of inputs, clock it, and land 1 ns after the edge.
   task automatic step(input logic [3:0] a, input logic [3:0] c);
      ante = a;
      cons = c;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      enable       = 1'b1;
      clear_sticky = 1'b0;
      ante         = 4'hF;
      cons         = 4'h0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      ante  = 4'h0;
   endtask

   initial begin
      // Reset held two clocks with every antecedent high
      do_reset();
      check("rst pending_a", pending_a, 4'h0);
      check("rst timeout_a", fire_timeout_a, 4'h0);
      check("rst early_e", fire_early_e, 4'h0);
      check("rst count_a", fire_count_a, 0);
      check("rst sticky_a", error_sticky_a, 0);
      check("rst count_s", fire_count_s, 0);

      // ch0 ante c0, cons c2: pending cycles 1..2, no fire
      step(4'b0001, 4'b0000);
      check("pass pend c1", pending_a, 4'b0001);
      step(4'b0000, 4'b0000);
      check("pass pend c2", pending_a, 4'b0001);
      step(4'b0000, 4'b0001);
      check("pass pend c3", pending_a, 4'b0000);
      check("pass no fire c3", fire_timeout_a, 4'b0000);
      repeat (3) step(4'b0000, 4'b0000);
      check("pass count_a", fire_count_a, 0);
      check("pass sticky_a", error_sticky_a, 0);
      check("pass count_e", fire_count_e, 0);

      // ch1 ante c0 (re-armed at c2, ignored), cons never: one timeout at c4
      step(4'b0010, 4'b0000);
      step(4'b0000, 4'b0000);
      step(4'b0010, 4'b0000);
      check("to pend c3", pending_a, 4'b0010);
      check("to none c3", fire_timeout_a, 4'b0000);
      step(4'b0000, 4'b0000);
      check("to fire c4", fire_timeout_a, 4'b0010);
      check("to pend c4", pending_a, 4'b0000);
      step(4'b0000, 4'b0000);
      check("to pulse c5", fire_timeout_a, 4'b0000);
      check("to sticky", error_sticky_a, 1);
      check("to count", fire_count_a, 1);
      repeat (4) begin
         step(4'b0000, 4'b0000);
         check("to no refire", fire_timeout_a, 4'b0000);
      end
      check("to count held", fire_count_a, 1);

      // Strict early: ch2 cons at c1 is early for MIN=2, legal for MIN=1
      do_reset();
      step(4'b0100, 4'b0000);
      step(4'b0000, 4'b0100);
      check("early fire_e c2", fire_early_e, 4'b0100);
      check("early timeout_e c2", fire_timeout_e, 4'b0000);
      check("early pend_e c2", pending_e, 4'b0000);
      check("min pass early_a", fire_early_a, 4'b0000);
      check("min pass pend_a", pending_a, 4'b0000);
      step(4'b0000, 4'b0000);
      check("early pulse_e c3", fire_early_e, 4'b0000);
      check("early count_e", fire_count_e, 1);
      check("early sticky_e", error_sticky_e, 1);
      check("min pass count_a", fire_count_a, 0);

      // Consequent exactly at MAX_DELAY is a pass
      step(4'b0001, 4'b0000);
      step(4'b0000, 4'b0000);
      step(4'b0000, 4'b0000);
      check("max pend c3", pending_a, 4'b0001);
      step(4'b0000, 4'b0001);
      check("max no fire", fire_timeout_a, 4'b0000);
      check("max pend c4", pending_a, 4'b0000);
      step(4'b0000, 4'b0000);
      check("max count_a", fire_count_a, 0);
      check("max count_e", fire_count_e, 1);

      // All channels time out together; second round saturates the 2-bit counter
      do_reset();
      step(4'hF, 4'h0);
      repeat (3) step(4'h0, 4'h0);
      check("all fire c4", fire_timeout_a, 4'hF);
      step(4'h0, 4'h0);
      check("all count_a", fire_count_a, 4);
      check("all count_s sat", fire_count_s, 3);
      step(4'hF, 4'h0);
      repeat (3) step(4'h0, 4'h0);
      step(4'h0, 4'h0);
      check("all2 count_a", fire_count_a, 8);
      check("all2 count_s sat", fire_count_s, 3);

      // enable drop closes ch3 window silently; totals hold until clear
      step(4'b1000, 4'b0000);
      step(4'b0000, 4'b0000);
      check("en pend c2", pending_a, 4'b1000);
      enable = 1'b0;
      step(4'b0000, 4'b0000);
      check("en pend c3", pending_a, 4'b0000);
      step(4'hF, 4'h0);
      check("en no fire c4", fire_timeout_a, 4'h0);
      check("en ante ignored", pending_a, 4'h0);
      step(4'h0, 4'h0);
      check("en no fire c5", fire_timeout_a, 4'h0);
      check("en sticky hold", error_sticky_a, 1);
      check("en count hold", fire_count_a, 8);
      enable       = 1'b1;
      clear_sticky = 1'b1;
      step(4'h0, 4'h0);
      clear_sticky = 1'b0;
      check("clr sticky", error_sticky_a, 0);
      check("clr count", fire_count_a, 0);

      // Clear coinciding with a fire: old total dropped, new fire kept
      step(4'hF, 4'h0);
      repeat (4) step(4'h0, 4'h0);
      check("pre-clr count_a", fire_count_a, 4);
      step(4'b0001, 4'h0);
      repeat (3) step(4'h0, 4'h0);
      check("clr+fire pulse", fire_timeout_a, 4'b0001);
      clear_sticky = 1'b1;
      step(4'h0, 4'h0);
      clear_sticky = 1'b0;
      check("clr+fire count_a", fire_count_a, 1);
      check("clr+fire sticky_a", error_sticky_a, 1);
      check("clr+fire count_s", fire_count_s, 1);

      // Reset mid-window abandons it without a fire
      step(4'b0001, 4'h0);
      step(4'h0, 4'h0);
      reset = 1'b1;
      step(4'h0, 4'h0);
      reset = 1'b0;
      check("midrst pend", pending_a, 4'h0);
      repeat (4) begin
         step(4'h0, 4'h0);
         check("midrst no fire", fire_timeout_a, 4'h0);
      end
      check("midrst count", fire_count_a, 0);
      check("midrst sticky", error_sticky_a, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
